// File: rtl/baw_pkg.sv
// -----------------------------------------------------------------------------
// baw_pkg
// Shared definitions for the Black-and-White round sequencer: controller state
// encoding, player encoding, comparator result codes and the default game size.
// -----------------------------------------------------------------------------
package baw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEAD    = 3'd1,
    ST_FOLLOW  = 3'd2,
    ST_RESOLVE = 3'd3,
    ST_CHECK   = 3'd4,
    ST_DONE    = 3'd5
  } baw_state_e;

  localparam logic PLAYER_P1 = 1'b0;
  localparam logic PLAYER_P2 = 1'b1;

  localparam logic [1:0] RES_DRAW = 2'b00;
  localparam logic [1:0] RES_P1   = 2'b01;
  localparam logic [1:0] RES_P2   = 2'b10;

  localparam int unsigned BAW_NUM_CARDS  = 9;
  localparam int unsigned BAW_MAX_ROUNDS = 9;

endpackage

// File: rtl/baw_card_pick.sv
// -----------------------------------------------------------------------------
// baw_card_pick
// Combinational card helper for the active player.
// Ports:
//   sel       in   switch selection, bit i = card i
//   mask      in   used-card mask of the active player
//   legal     out  sel is exactly one-hot and names an unused card
//   sel_idx   out  binary index of the selected card (valid when one-hot)
//   low_valid out  at least one card is still unused
//   low_idx   out  index of the lowest unused card
// -----------------------------------------------------------------------------
module baw_card_pick import baw_pkg::*; #(
  parameter int unsigned NUM_CARDS = BAW_NUM_CARDS
) (
  input  logic [NUM_CARDS-1:0] sel,
  input  logic [NUM_CARDS-1:0] mask,
  output logic                 legal,
  output logic [3:0]           sel_idx,
  output logic                 low_valid,
  output logic [3:0]           low_idx
);

  // One-hot check, legality against the mask and index encoding.
  always_comb begin
    legal   = 1'b0;
    sel_idx = 4'd0;
    for (int i = 0; i < int'(NUM_CARDS); i++) begin
      if (sel[i]) begin
        sel_idx = 4'(i);
      end else begin
        sel_idx = sel_idx;
      end
    end
    if (($countones(sel) == 32'd1) && ((sel & mask) == '0)) begin
      legal = 1'b1;
    end else begin
      legal = 1'b0;
    end
  end

  // Lowest unused card: scan downwards so the last hit is the lowest index.
  always_comb begin
    low_valid = 1'b0;
    low_idx   = 4'd0;
    for (int i = int'(NUM_CARDS) - 1; i >= 0; i--) begin
      if (!mask[i]) begin
        low_valid = 1'b1;
        low_idx   = 4'(i);
      end else begin
        low_valid = low_valid;
      end
    end
  end

endmodule

// File: rtl/baw_round_ctrl.sv
// -----------------------------------------------------------------------------
// baw_round_ctrl
// Round sequencer for the two-player Black-and-White card game: turn order,
// card legality, used-card masks, score strobe and end-of-game decision.
// Optional feature macro: BAW_TURN_TIMEOUT_EN (auto-play lowest unused card
// after TURN_TIMEOUT cycles in a turn and pulse timeout).
// Ports:
//   clk, reset_n                clock, asynchronous active-low reset
//   start, abort                new game (from IDLE/DONE), return to IDLE
//   confirm_p1, confirm_p2, sel player commits the switch selection
//   match_result, finish        comparator result, finish detector
//   p1_card, p2_card            last committed card per player
//   p1_used, p2_used            used-card masks
//   turn, lead, round           active player, round leader, completed rounds
//   score_pulse, illegal,
//   timeout, done               strobes and end-of-game flag
// -----------------------------------------------------------------------------
module baw_round_ctrl import baw_pkg::*; #(
  parameter int unsigned NUM_CARDS    = BAW_NUM_CARDS,
  parameter int unsigned MAX_ROUNDS   = BAW_MAX_ROUNDS,
  parameter int          TURN_TIMEOUT = 500_000_000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 confirm_p1,
  input  logic                 confirm_p2,
  input  logic [NUM_CARDS-1:0] sel,
  input  logic [1:0]           match_result,
  input  logic                 finish,
  output logic [3:0]           p1_card,
  output logic [3:0]           p2_card,
  output logic [NUM_CARDS-1:0] p1_used,
  output logic [NUM_CARDS-1:0] p2_used,
  output logic                 turn,
  output logic                 lead,
  output logic [3:0]           round,
  output logic                 score_pulse,
  output logic                 illegal,
  output logic                 timeout,
  output logic                 done
);

  localparam logic [3:0]           LAST_ROUND = 4'(MAX_ROUNDS);
  localparam logic [NUM_CARDS-1:0] ONE_BIT    = {{(NUM_CARDS-1){1'b0}}, 1'b1};

  baw_state_e           state_r, state_next_s;
  logic [3:0]           p1_card_r, p2_card_r, p1_card_next_s, p2_card_next_s;
  logic [NUM_CARDS-1:0] p1_used_r, p2_used_r, p1_used_next_s, p2_used_next_s;
  logic                 turn_r, turn_next_s, lead_r, lead_next_s;
  logic [3:0]           round_r, round_next_s;
  logic                 score_r, score_next_s, illegal_r, illegal_next_s;
  logic                 timeout_r, timeout_next_s, done_r, done_next_s;

  logic                 active_s, act_confirm_s, expire_s;
  logic [NUM_CARDS-1:0] active_mask_s, play_bit_s;
  logic                 legal_s, low_valid_s;
  logic [3:0]           sel_idx_s, low_idx_s, play_idx_s;

  // In FOLLOW the non-leader plays; everywhere else the leader is "active".
  assign active_s      = (state_r == ST_FOLLOW) ? ~lead_r : lead_r;
  assign act_confirm_s = (active_s == PLAYER_P2) ? confirm_p2 : confirm_p1;
  assign active_mask_s = (active_s == PLAYER_P2) ? p2_used_r : p1_used_r;
  // A real confirm wins over the auto-play when both happen together.
  assign play_idx_s    = act_confirm_s ? sel_idx_s : low_idx_s;
  assign play_bit_s    = ONE_BIT << play_idx_s;

  baw_card_pick #(.NUM_CARDS(NUM_CARDS)) u_pick (
    .sel       (sel),
    .mask      (active_mask_s),
    .legal     (legal_s),
    .sel_idx   (sel_idx_s),
    .low_valid (low_valid_s),
    .low_idx   (low_idx_s)
  );

`ifdef BAW_TURN_TIMEOUT_EN
  logic [31:0] turn_cnt_r;
  logic        in_turn_s;

  assign in_turn_s = (state_r == ST_LEAD) || (state_r == ST_FOLLOW);
  assign expire_s  = in_turn_s && (turn_cnt_r == 32'(TURN_TIMEOUT - 1));

  // Per-turn cycle counter; restarts on every state change and on expiry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      turn_cnt_r <= 32'd0;
    end else if (!in_turn_s || (state_next_s != state_r) || expire_s) begin
      turn_cnt_r <= 32'd0;
    end else begin
      turn_cnt_r <= turn_cnt_r + 32'd1;
    end
  end
`else
  // No turn limit in this build: the comparison is constant false.
  assign expire_s = (TURN_TIMEOUT < 0);
`endif

  // Next-state and next-output computation.
  always_comb begin
    state_next_s   = state_r;
    p1_card_next_s = p1_card_r;
    p2_card_next_s = p2_card_r;
    p1_used_next_s = p1_used_r;
    p2_used_next_s = p2_used_r;
    lead_next_s    = lead_r;
    round_next_s   = round_r;
    turn_next_s    = turn_r;
    illegal_next_s = 1'b0;
    timeout_next_s = 1'b0;

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          p1_card_next_s = 4'd0;
          p2_card_next_s = 4'd0;
          p1_used_next_s = '0;
          p2_used_next_s = '0;
          round_next_s   = 4'd0;
          lead_next_s    = PLAYER_P1;
          state_next_s   = ST_LEAD;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_LEAD, ST_FOLLOW: begin
        if (act_confirm_s && !legal_s) begin
          illegal_next_s = 1'b1;
        end else if (act_confirm_s || (expire_s && low_valid_s)) begin
          timeout_next_s = ~act_confirm_s;
          if (active_s == PLAYER_P2) begin
            p2_card_next_s = play_idx_s;
            p2_used_next_s = p2_used_r | play_bit_s;
          end else begin
            p1_card_next_s = play_idx_s;
            p1_used_next_s = p1_used_r | play_bit_s;
          end
          state_next_s = (state_r == ST_LEAD) ? ST_FOLLOW : ST_RESOLVE;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_RESOLVE: begin
        case (match_result)
          RES_P1:  lead_next_s = PLAYER_P1;
          RES_P2:  lead_next_s = PLAYER_P2;
          default: lead_next_s = lead_r;
        endcase
        round_next_s = round_r + 4'd1;
        state_next_s = ST_CHECK;
      end
      ST_CHECK: begin
        if (finish || (round_r == LAST_ROUND)) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_LEAD;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase

    // Abort overrides everything computed above.
    if (abort) begin
      state_next_s   = ST_IDLE;
      p1_card_next_s = 4'd0;
      p2_card_next_s = 4'd0;
      p1_used_next_s = '0;
      p2_used_next_s = '0;
      lead_next_s    = PLAYER_P1;
      round_next_s   = 4'd0;
      illegal_next_s = 1'b0;
      timeout_next_s = 1'b0;
    end else begin
      state_next_s = state_next_s;
    end

    case (state_next_s)
      ST_LEAD:   turn_next_s = lead_next_s;
      ST_FOLLOW: turn_next_s = ~lead_next_s;
      ST_IDLE:   turn_next_s = 1'b0;
      default:   turn_next_s = turn_r;
    endcase

    score_next_s = (state_next_s == ST_RESOLVE);
    done_next_s  = (state_next_s == ST_DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      p1_card_r <= 4'd0;
      p2_card_r <= 4'd0;
      p1_used_r <= '0;
      p2_used_r <= '0;
      turn_r    <= 1'b0;
      lead_r    <= 1'b0;
      round_r   <= 4'd0;
      score_r   <= 1'b0;
      illegal_r <= 1'b0;
      timeout_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      p1_card_r <= p1_card_next_s;
      p2_card_r <= p2_card_next_s;
      p1_used_r <= p1_used_next_s;
      p2_used_r <= p2_used_next_s;
      turn_r    <= turn_next_s;
      lead_r    <= lead_next_s;
      round_r   <= round_next_s;
      score_r   <= score_next_s;
      illegal_r <= illegal_next_s;
      timeout_r <= timeout_next_s;
      done_r    <= done_next_s;
    end
  end

  assign p1_card     = p1_card_r;
  assign p2_card     = p2_card_r;
  assign p1_used     = p1_used_r;
  assign p2_used     = p2_used_r;
  assign turn        = turn_r;
  assign lead        = lead_r;
  assign round       = round_r;
  assign score_pulse = score_r;
  assign illegal     = illegal_r;
  assign timeout     = timeout_r;
  assign done        = done_r;

endmodule

// File: tb/tb_baw_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_baw_round_ctrl
// Self-checking bench for baw_round_ctrl. A game-level model (used-card sets,
// cards, leader, round count, plays made this round) predicts every output.
// -----------------------------------------------------------------------------
module tb_baw_round_ctrl;

  localparam int NC = 9;
  localparam int MR = 9;

  logic          clk = 1'b0;
  logic          reset_n, start, abort, confirm_p1, confirm_p2, finish;
  logic [NC-1:0] sel;
  logic [1:0]    match_result;
  logic [3:0]    p1_card, p2_card, round;
  logic [NC-1:0] p1_used, p2_used;
  logic          turn, lead, score_pulse, illegal, timeout, done;

  baw_round_ctrl #(.NUM_CARDS(NC), .MAX_ROUNDS(MR), .TURN_TIMEOUT(500_000_000)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .confirm_p1(confirm_p1), .confirm_p2(confirm_p2), .sel(sel),
    .match_result(match_result), .finish(finish),
    .p1_card(p1_card), .p2_card(p2_card), .p1_used(p1_used), .p2_used(p2_used),
    .turn(turn), .lead(lead), .round(round), .score_pulse(score_pulse),
    .illegal(illegal), .timeout(timeout), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Game-level reference model
  logic [NC-1:0] m_used [2];
  logic [3:0]    m_card [2];
  bit            m_lead, m_inplay, m_done;
  int            m_round, m_plays;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_used[0] = '0; m_used[1] = '0;
    m_card[0] = 4'd0; m_card[1] = 4'd0;
    m_lead = 1'b0; m_round = 0; m_plays = 0; m_inplay = 1'b0; m_done = 1'b0;
  endtask

  function automatic logic [3:0] idx_of(input logic [NC-1:0] s);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < NC; i++) if (s[i]) r = 4'(i);
    return r;
  endfunction

  function automatic logic [NC-1:0] lowest(input bit p);
    logic [NC-1:0] r;
    r = '0;
    for (int i = NC - 1; i >= 0; i--) if (!m_used[p][i]) begin r = '0; r[i] = 1'b1; end
    return r;
  endfunction

  function automatic bit active_player();
    return (m_plays == 0) ? m_lead : ~m_lead;
  endfunction

  task automatic chk_all(input string tag, input bit exp_score, input bit exp_ill);
    check({tag, ".p1_card"}, 32'(p1_card), 32'(m_card[0]));
    check({tag, ".p2_card"}, 32'(p2_card), 32'(m_card[1]));
    check({tag, ".p1_used"}, 32'(p1_used), 32'(m_used[0]));
    check({tag, ".p2_used"}, 32'(p2_used), 32'(m_used[1]));
    check({tag, ".lead"}, 32'(lead), 32'(m_lead));
    check({tag, ".round"}, 32'(round), 32'(m_round));
    check({tag, ".done"}, 32'(done), 32'(m_done));
    check({tag, ".score_pulse"}, 32'(score_pulse), 32'(exp_score));
    check({tag, ".illegal"}, 32'(illegal), 32'(exp_ill));
    check({tag, ".timeout"}, 32'(timeout), 32'd0);
    if (m_inplay && m_plays < 2) check({tag, ".turn"}, 32'(turn), 32'(active_player()));
    else if (!m_inplay && !m_done) check({tag, ".turn"}, 32'(turn), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    if (!m_inplay) begin
      model_reset();
      m_inplay = 1'b1;
    end
    chk_all("start", 1'b0, 1'b0);
  endtask

  task automatic do_abort(input bit with_start, input bit with_conf);
    abort = 1'b1; start = with_start; confirm_p1 = with_conf; confirm_p2 = with_conf;
    tick();
    abort = 1'b0; start = 1'b0; confirm_p1 = 1'b0; confirm_p2 = 1'b0;
    model_reset();
    chk_all("abort", 1'b0, 1'b0);
    tick();
    chk_all("abort_after", 1'b0, 1'b0);
  endtask

  // One confirm attempt; a completed round is followed through RESOLVE and CHECK.
  task automatic do_confirm(input bit c1, input bit c2, input logic [NC-1:0] s,
                            input logic [1:0] mres, input bit fin);
    bit act, ac, exp_ill;
    act = active_player();
    confirm_p1 = c1; confirm_p2 = c2; sel = s; match_result = mres;
    tick();
    confirm_p1 = 1'b0; confirm_p2 = 1'b0;
    exp_ill = 1'b0;
    ac = act ? c2 : c1;
    if (m_inplay && ac) begin
      if (($countones(s) == 1) && ((s & m_used[act]) == '0)) begin
        m_card[act] = idx_of(s);
        m_used[act] = m_used[act] | s;
        m_plays++;
      end else begin
        exp_ill = 1'b1;
      end
    end
    chk_all("confirm", m_plays == 2, exp_ill);
    if (m_plays == 2) begin
      tick();
      if (mres == 2'b01) m_lead = 1'b0;
      else if (mres == 2'b10) m_lead = 1'b1;
      m_round++;
      chk_all("resolve", 1'b0, 1'b0);
      finish = fin;
      tick();
      finish = 1'b0;
      m_plays = 0;
      if (fin || m_round == MR) begin
        m_inplay = 1'b0;
        m_done = 1'b1;
      end
      chk_all("check", 1'b0, 1'b0);
    end else begin
      tick();
      chk_all("hold", 1'b0, 1'b0);
    end
  endtask

  task automatic play_lowest(input logic [1:0] mres, input bit fin);
    bit act;
    act = active_player();
    do_confirm(!act, act, lowest(act), mres, fin);
  endtask

  function automatic logic [NC-1:0] rand_sel(input bit p);
    logic [NC-1:0] v;
    int r;
    v = '0;
    r = $urandom_range(9, 0);
    if (r < 4) v = lowest(p);
    else if (r < 8) v[$urandom_range(NC - 1, 0)] = 1'b1;
    else v = NC'($urandom);
    return v;
  endfunction

  initial begin
    bit act;
    int r;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; confirm_p1 = 1'b0; confirm_p2 = 1'b0;
    sel = '0; match_result = 2'b00; finish = 1'b0;
    model_reset();
    tick();
    chk_all("reset", 1'b0, 1'b0);
    reset_n = 1'b1;
    tick();
    chk_all("idle", 1'b0, 1'b0);

    // Round 1: P1 plays 5, P2 plays 3, P1 wins
    do_start();
    do_confirm(1'b1, 1'b0, 9'b000100000, 2'b00, 1'b0);
    do_confirm(1'b0, 1'b1, 9'b000001000, 2'b01, 1'b0);
    check("tp1.p1_card", 32'(p1_card), 32'd5);
    check("tp1.p2_card", 32'(p2_card), 32'd3);
    check("tp1.round", 32'(round), 32'd1);
    check("tp1.p1_used", 32'(p1_used), 32'h20);

    // Round 2: reuse of card 5 and a two-hot selection are rejected
    do_confirm(1'b1, 1'b0, 9'b000100000, 2'b00, 1'b0);
    do_confirm(1'b1, 1'b0, 9'b000000011, 2'b00, 1'b0);
    do_confirm(1'b1, 1'b0, 9'b000000000, 2'b00, 1'b0);
    do_confirm(1'b1, 1'b0, 9'b000000001, 2'b00, 1'b0);
    do_confirm(1'b0, 1'b1, 9'b000000010, 2'b10, 1'b0);
    check("tp2.lead", 32'(lead), 32'd1);

    // Round 3: P2 leads; stray P1 confirm ignored, simultaneous confirms -> P2
    do_confirm(1'b1, 1'b0, 9'b000000010, 2'b00, 1'b0);
    do_confirm(1'b1, 1'b1, 9'b000000100, 2'b00, 1'b0);
    check("tp3.p2_card", 32'(p2_card), 32'd2);
    do_start();  // ignored mid-game
    do_confirm(1'b0, 1'b0, 9'b000000100, 2'b00, 1'b0);
    do_confirm(1'b1, 1'b1, 9'b000000100, 2'b11, 1'b0);

    // Finish the game with finish held low
    for (int k = 0; k < 40 && m_inplay; k++) play_lowest(2'($urandom), 1'b0);
    check("full.round", 32'(round), 32'd9);
    check("full.p1_used", 32'(p1_used), 32'h1FF);
    check("full.p2_used", 32'(p2_used), 32'h1FF);
    check("full.done", 32'(done), 32'd1);
    do_confirm(1'b1, 1'b1, 9'b000000001, 2'b01, 1'b0);  // no effect in DONE

    // finish asserted after round 5
    do_start();
    for (int k = 0; k < 40 && m_inplay; k++) play_lowest(2'($urandom), m_round == 4);
    check("fin5.round", 32'(round), 32'd5);
    check("fin5.done", 32'(done), 32'd1);

    // Abort in FOLLOW, with start and confirms alongside
    do_start();
    play_lowest(2'b00, 1'b0);
    do_abort(1'b1, 1'b1);

    // Reset during RESOLVE
    do_start();
    play_lowest(2'b00, 1'b0);
    act = active_player();
    confirm_p1 = !act; confirm_p2 = act; sel = lowest(act);
    tick();
    confirm_p1 = 1'b0; confirm_p2 = 1'b0;
    check("rst.score_pulse", 32'(score_pulse), 32'd1);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk_all("rst_in", 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk_all("rst_after", 1'b0, 1'b0);
    tick();
    chk_all("rst_after2", 1'b0, 1'b0);

    // Randomized games
    for (int g = 0; g < 8; g++) begin
      do_start();
      for (int k = 0; k < 80 && m_inplay; k++) begin
        if ($urandom_range(59, 0) == 0) begin
          do_abort($urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1);
        end else begin
          act = active_player();
          r = $urandom_range(3, 0);
          do_confirm((r == 1) || ((r != 2) ? !act : act),
                     (r == 1) || ((r != 2) ? act : !act),
                     rand_sel(act), 2'($urandom), $urandom_range(7, 0) == 0);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
